// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, reset PC,
// fetch-pair width and the request-FIFO entry layout.
package fetch_ctrl_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;
   localparam int unsigned FETCH_PAIR_W     = 64;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_RUN,
      ST_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  plv;
      logic        drop;
   } req_ent_t;

endpackage

// File: rtl/fetch_req_fifo.sv
// In-order tracker for outstanding icache requests; drop_all_i marks every
// held entry stale so its response is discarded on arrival.
module fetch_req_fifo
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     rstn,
   input  logic     push_i,
   input  req_ent_t entry_i,
   input  logic     pop_i,
   input  logic     drop_all_i,
   output req_ent_t head_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   req_ent_t      mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (drop_all_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i].drop <= 1'b1;
         end
         if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: credit-gated icache request issue, response forwarding to
// the fetch buffer, redirect/drain handling. Perf counters: FETCH_CTRL_PERF_EN.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned QDEPTH       = 16,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   input  logic                    stall,
   input  logic [1:0]              plv_in,
   input  logic [1:0]              deq_cnt,
   output logic                    icache_req_valid,
   input  logic                    icache_req_ready,
   output logic [31:0]             icache_req_pc,
   input  logic                    icache_rsp_valid,
   output logic                    icache_rsp_ready,
   input  logic [FETCH_PAIR_W-1:0] icache_rsp_data,
   output logic                    fb_valid,
   output logic [31:0]             fb_pc,
   output logic [FETCH_PAIR_W-1:0] fb_ir,
   output logic                    fb_two,
   output logic [1:0]              fb_plv,
   output logic [31:0]             perf_credit_stall,
   output logic [31:0]             perf_drop
);

   localparam int unsigned OW = $clog2(QDEPTH + 1);
   localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

   fetch_state_e            state_q, state_d;
   logic [31:0]             pc_q, pc_d;
   logic [IW-1:0]           inflight_q, inflight_d;
   logic [OW-1:0]           occ_q, occ_d;
   logic                    fb_valid_q;
   logic [31:0]             fb_pc_q;
   logic [FETCH_PAIR_W-1:0] fb_ir_q;
   logic                    fb_two_q;
   logic [1:0]              fb_plv_q;

   req_ent_t    head, push_ent;
   logic        room_ok, credit_ok, issue, req_fire, rsp_fire, rsp_keep, rsp_two;
   logic [31:0] occ_sum, remain;

   // Reserve two slots per outstanding request, including the one about to issue.
   assign credit_ok = (32'(QDEPTH) - 32'(occ_q)) >= ((32'(inflight_q) + 32'd1) << 1);
   assign room_ok   = (state_q == ST_RUN) && !stall && !redirect_valid &&
                      (32'(inflight_q) < 32'(MAX_INFLIGHT));
   assign issue     = room_ok && credit_ok;

   assign icache_req_valid = issue;
   assign icache_req_pc    = {pc_q[31:2], 2'b00};
   assign icache_rsp_ready = !stall;

   assign req_fire = issue && icache_req_ready;
   assign rsp_fire = icache_rsp_valid && !stall;
   assign rsp_keep = rsp_fire && !head.drop && !redirect_valid;
   assign rsp_two  = !head.pc[2];
   assign push_ent = '{pc: pc_q, plv: plv_in, drop: 1'b0};
   assign occ_sum  = 32'(occ_q) + (rsp_keep ? (rsp_two ? 32'd2 : 32'd1) : 32'd0);

   fetch_req_fifo #(.DEPTH(MAX_INFLIGHT)) u_req_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push_i    (req_fire),
      .entry_i   (push_ent),
      .pop_i     (rsp_fire),
      .drop_all_i(redirect_valid),
      .head_o    (head)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      occ_d      = occ_q;
      remain     = 32'(inflight_q) - (rsp_fire ? 32'd1 : 32'd0);
      inflight_d = req_fire ? IW'(remain + 32'd1) : IW'(remain);

      if (redirect_valid) begin
         pc_d  = redirect_pc;
         occ_d = '0;
      end else begin
         if (req_fire) pc_d = {pc_q[31:3] + 29'd1, 3'b000};
         occ_d = (occ_sum < 32'(deq_cnt)) ? '0 : OW'(occ_sum - 32'(deq_cnt));
      end

      unique case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN:   if (redirect_valid && remain != 32'd0) state_d = ST_DRAIN;
         ST_DRAIN: if (inflight_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_RESET;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         occ_q      <= '0;
         fb_valid_q <= 1'b0;
         fb_pc_q    <= '0;
         fb_ir_q    <= '0;
         fb_two_q   <= 1'b0;
         fb_plv_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         fb_valid_q <= rsp_keep;
         if (rsp_keep) begin
            fb_pc_q  <= head.pc;
            fb_ir_q  <= icache_rsp_data;
            fb_two_q <= rsp_two;
            fb_plv_q <= head.plv;
         end
      end
   end

   assign fb_valid = fb_valid_q;
   assign fb_pc    = fb_pc_q;
   assign fb_ir    = fb_ir_q;
   assign fb_two   = fb_two_q;
   assign fb_plv   = fb_plv_q;

   occ_never_negative: assert property (@(posedge clk) disable iff (!rstn)
      !redirect_valid |-> (occ_sum >= 32'(deq_cnt)));

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_cs_q, perf_drop_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_cs_q   <= '0;
         perf_drop_q <= '0;
      end else begin
         perf_cs_q   <= perf_cs_q + 32'(room_ok && !credit_ok);
         perf_drop_q <= perf_drop_q + 32'(rsp_fire && !rsp_keep);
      end
   end

   assign perf_credit_stall = perf_cs_q;
   assign perf_drop         = perf_drop_q;
`else
   assign perf_credit_stall = '0;
   assign perf_drop         = '0;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Front-end fetch sequencer between the PC/redirect logic, the instruction cache and the fetch buffer. Each request fetches one 8-byte-aligned instruction pair, and the block generates the fetch PC. It issues requests to the icache only when the fetch buffer has guaranteed space for every outstanding response, and forwards responses to the buffer with the one/two-valid flag. On a redirect it re-steers the PC and discards stale in-flight responses.

## Interface
- QDEPTH, 16: fetch buffer entries (instruction slots).
- MAX_INFLIGHT, 2: maximum outstanding icache requests.
- RESET_PC, 32'h1c00_0000: PC loaded on reset.
- clk  in  1  clock, all state on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  branch/exception redirect; also flushes the fetch buffer this cycle.
- redirect_pc  in  32  redirect target, word-aligned.
- stall  in  1  back-end stall; fetch buffer frozen.
- plv_in  in  2  current privilege level, captured per request.
- deq_cnt  in  2  instructions consumed from the fetch buffer this cycle (0..2; 3 is illegal).
- icache_req_valid  out  1  request valid.
- icache_req_ready  in  1  icache accepts request.
- icache_req_pc  out  32  request address, bits [1:0] zero.
- icache_rsp_valid  in  1  response valid, in request order.
- icache_rsp_ready  out  1  = !stall.
- icache_rsp_data  in  64  [31:0] instr at pc, [63:32] instr at pc+4.
- fb_valid  out  1  push to fetch buffer.
- fb_pc  out  32  PC of fb_ir[31:0].
- fb_ir  out  64  instruction pair.
- fb_two  out  1  1 = both valid, 0 = only [31:0] valid.
- fb_plv  out  2  plv of the request.
- perf_credit_stall, perf_drop  out  32 each  performance counters (see Configuration).

## Operation
- State held: pc, inflight count (0..MAX_INFLIGHT), occupancy (0..QDEPTH), state FSM, and a MAX_INFLIGHT-deep request FIFO holding {pc, plv, drop}.
- Issue condition: state==RUN and !stall and !redirect_valid and inflight<MAX_INFLIGHT and QDEPTH − occupancy ≥ 2·(inflight+1).
- On a request handshake:
  - push {pc, plv_in, 0} into the request FIFO;
  - inflight+1;
  - pc ← {pc[31:3]+1, 3'b000}.
- fb_two for a request = (pc[2]==0); the pc+4 slot is valid only when pc[2]==0.
- On a response handshake:
  - pop the request FIFO;
  - inflight−1;
  - if the drop bit is clear: fb outputs are loaded, and occupancy increases by 1+fb_two;
  - if the drop bit is set: the response is discarded.
- Occupancy update each cycle: occupancy + pushed − deq_cnt. The value is saturated at 0 and asserted never to go below 0.
- Redirect:
  - pc ← redirect_pc;
  - occupancy ← 0, and any same-cycle push or deq is ignored;
  - drop bit set on every FIFO entry;
  - any same-cycle response is treated as dropped.
- FSM states and transitions:
  - RESET → RUN on the first clock after reset release.
  - RUN → DRAIN on a redirect with inflight>0 (after accounting for a same-cycle response pop).
  - DRAIN: no issue; responses are popped and discarded.
  - DRAIN → RUN when inflight reaches 0.
  - A redirect during DRAIN reloads pc and stays in DRAIN.
- A redirect with inflight==0 stays in RUN; issue resumes the next cycle.

## Timing
- Reset values: pc=RESET_PC, state=RESET, inflight=0, occupancy=0, all fb_* outputs 0, icache_req_valid=0, perf counters 0.
- icache_req_valid/icache_req_pc are combinational from registered state, stall and redirect_valid. Once asserted, pc is held until ready or redirect.
- Response → fb_valid latency: 1 cycle (registered). fb_valid is a one-cycle pulse per accepted response.
- Earliest issue after reset: cycle 2 after rstn rises.
- Earliest issue after redirect with inflight==0: the cycle after the redirect, at redirect_pc.
- Simultaneous request and response handshake: inflight unchanged. The credit check uses the registered inflight, which is conservative.
- Reset mid-operation: all state is cleared immediately and asynchronously. Late icache responses are the icache's responsibility, because the icache shares rstn.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - perf_credit_stall counts RUN cycles with !stall where issue is blocked only by credit;
  - perf_drop counts discarded responses;
  - both counters wrap at 2^32.
- FETCH_CTRL_PERF_EN undefined: both ports are tied to 0 and no counter logic is built.

## Structure
- Shared package: the FSM state enum (RESET, RUN, DRAIN), RESET_PC, the fetch-pair width (64), and the request-FIFO entry struct {pc, plv, drop}.
- One sub-module: fetch_req_fifo, a small synchronous FIFO of depth MAX_INFLIGHT with a broadcast "set all drop bits" input.

## Test plan
- Reset, icache always ready, 1-cycle response, deq_cnt=2 every cycle → requests at 0x1c000000, 0x1c000008, 0x1c000010…; fb_two=1; fb_pc sequence matches.
- redirect_pc=0x1c000104 → next request pc 0x1c000104 with fb_two=0, then 0x1c000108 with fb_two=1.
- deq_cnt=0, QDEPTH=16, immediate responses → exactly 8 responses forwarded. Further issue is blocked; after one deq_cnt=2, one more request is issued.
- Two requests in flight, then redirect to 0x1c000200 → state DRAIN; both responses are dropped (fb_valid stays 0, perf_drop=2 with macro). The first request after the drain is 0x1c000200.
- stall=1 for 5 cycles with one response pending → icache_rsp_ready=0 and no issue; after stall drops, the response is forwarded one cycle after its handshake.
- Assert rstn low mid-DRAIN → all outputs and counters return to reset values; after release, first request at RESET_PC.
